// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for mem_responder and its backing array.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } state_e;

   localparam int unsigned CNT_W = 4;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous 32-bit RAM; write-first registered read data.
module mem_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[idx] <= wdata;
            rdata_q    <= wdata;
         end else begin
            rdata_q    <= mem_q[idx];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Two-port (instruction/data) memory responder over one single-ported array.
// Build option: MEM_ALIGN_CHECK_EN flags misaligned data accesses via d_err.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load_n,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_valid,
   input  logic        d_load_n,
   input  logic        d_wen_n,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_err
);

   localparam int unsigned AW = idx_width(DEPTH);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [AW-1:0]     idx_q;
   logic [31:0]       wdata_q;
   logic              wr_q;
   logic              mis_q;
   logic              i_done_q;
   logic              d_done_q;
   logic              i_valid_q;
   logic              d_valid_q;
   logic              d_err_q;
   logic [31:0]       i_hold_q;
   logic [31:0]       d_hold_q;

   logic              i_pend;
   logic              d_pend;
   logic              d_mis;
   logic              fire;
   logic              arr_en;
   logic              arr_we;
   logic [31:0]       arr_rdata;
   logic              unused_addr;

`ifdef MEM_ALIGN_CHECK_EN
   assign d_mis = (d_addr[1:0] != 2'b00);
`else
   assign d_mis = 1'b0;
`endif

   assign unused_addr = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

   assign i_pend = !i_load_n && !i_done_q;
   assign d_pend = (!d_load_n || !d_wen_n) && !d_done_q;
   // Gating with rst keeps an aborted access from touching the array.
   assign fire   = (state_q != IDLE) && (cnt_q == '0) && !rst;
   assign arr_en = fire && !mis_q;
   assign arr_we = arr_en && wr_q;

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         d_err_q   <= 1'b0;
         i_hold_q  <= '0;
         d_hold_q  <= '0;
      end else begin
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         d_err_q   <= 1'b0;
         if (i_valid_q) i_hold_q <= arr_rdata;
         if (d_valid_q) d_hold_q <= arr_rdata;
         if (i_load_n) i_done_q <= 1'b0;
         if (d_load_n && d_wen_n) d_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_pend) begin
                  state_q <= D_BUSY;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  idx_q   <= d_addr[AW+1:2];
                  wdata_q <= d_wdata;
                  wr_q    <= !d_wen_n;
                  mis_q   <= d_mis;
               end else if (i_pend) begin
                  state_q <= I_BUSY;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  idx_q   <= i_addr[AW+1:2];
                  wr_q    <= 1'b0;
                  mis_q   <= 1'b0;
               end
            end
            default: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  if (state_q == D_BUSY) begin
                     d_done_q <= 1'b1;
                     if (mis_q) d_err_q   <= 1'b1;
                     else       d_valid_q <= 1'b1;
                  end else begin
                     i_done_q  <= 1'b1;
                     i_valid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   // Array read data is live during the valid cycle, then latched per port.
   assign i_rdata = i_valid_q ? arr_rdata : i_hold_q;
   assign d_rdata = d_valid_q ? arr_rdata : d_hold_q;
   assign i_valid = i_valid_q;
   assign d_valid = d_valid_q;
   assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder at LATENCY 1, 3 and 4.
module tb_mem_responder;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_load_n [3];
   logic [31:0] i_addr   [3];
   logic [31:0] i_rdata  [3];
   logic        i_valid  [3];
   logic        d_load_n [3];
   logic        d_wen_n  [3];
   logic [31:0] d_addr   [3];
   logic [31:0] d_wdata  [3];
   logic [31:0] d_rdata  [3];
   logic        d_valid  [3];
   logic        d_err    [3];

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [3][1024];
   logic [31:0] lst_i [3];
   logic [31:0] lst_d [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder #(
         .DEPTH   (1024),
         .LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 4))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .i_load_n (i_load_n[g]),
         .i_addr   (i_addr[g]),
         .i_rdata  (i_rdata[g]),
         .i_valid  (i_valid[g]),
         .d_load_n (d_load_n[g]),
         .d_wen_n  (d_wen_n[g]),
         .d_addr   (d_addr[g]),
         .d_wdata  (d_wdata[g]),
         .d_rdata  (d_rdata[g]),
         .d_valid  (d_valid[g]),
         .d_err    (d_err[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % 32'd1024);
   endfunction

   task automatic xfer(input int d, input bit dp, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input string nm);
      int n;
      bit got;
      bit err_exp;
      int w;
      logic [31:0] exp_v;
      w = widx(addr);
      err_exp = dp && ALIGN && (addr[1:0] != 2'b00);
      @(negedge clk);
      if (dp) begin
         d_addr[d]   = addr;
         d_wdata[d]  = wd;
         d_wen_n[d]  = !wr;
         d_load_n[d] = wr ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
         i_addr[d]   = addr;
         i_load_n[d] = 1'b0;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            i_addr[d]  = $urandom;
            d_addr[d]  = $urandom;
            d_wdata[d] = $urandom;
         end
         got = dp ? (d_valid[d] || d_err[d]) : i_valid[d];
      end
      i_load_n[d] = 1'b1;
      d_load_n[d] = 1'b1;
      d_wen_n[d]  = 1'b1;
      total++;
      if (!got || n != lat_of(d) + 1) begin
         bad++;
         $display("FAIL %s latency dut%0d: got=%0b edges=%0d expected edges=%0d", nm, d, got, n, lat_of(d) + 1);
      end
      if (err_exp) exp_v = lst_d[d];
      else if (dp && wr) begin
         exp_v = wd;
         mem_m[d][w] = wd;
      end else exp_v = mem_m[d][w];
      if (got) begin
         if (dp) begin
            total++;
            if (d_valid[d] !== !err_exp || d_err[d] !== err_exp) begin
               bad++;
               $display("FAIL %s flags dut%0d: valid=%0b err=%0b expected valid=%0b err=%0b",
                        nm, d, d_valid[d], d_err[d], !err_exp, err_exp);
            end
            total++;
            if (d_rdata[d] !== exp_v) begin
               bad++;
               $display("FAIL %s d_rdata dut%0d: got=%h expected=%h", nm, d, d_rdata[d], exp_v);
            end
            total++;
            if (i_rdata[d] !== lst_i[d]) begin
               bad++;
               $display("FAIL %s i_rdata hold dut%0d: got=%h expected=%h", nm, d, i_rdata[d], lst_i[d]);
            end
            lst_d[d] = exp_v;
         end else begin
            total++;
            if (i_rdata[d] !== exp_v) begin
               bad++;
               $display("FAIL %s i_rdata dut%0d: got=%h expected=%h", nm, d, i_rdata[d], exp_v);
            end
            total++;
            if (d_rdata[d] !== lst_d[d]) begin
               bad++;
               $display("FAIL %s d_rdata hold dut%0d: got=%h expected=%h", nm, d, d_rdata[d], lst_d[d]);
            end
            lst_i[d] = exp_v;
         end
      end
      @(posedge clk);
      #1;
      total++;
      if (i_valid[d] !== 1'b0 || d_valid[d] !== 1'b0 || d_err[d] !== 1'b0 ||
          i_rdata[d] !== lst_i[d] || d_rdata[d] !== lst_d[d]) begin
         bad++;
         $display("FAIL %s after-pulse dut%0d: iv=%0b dv=%0b de=%0b ir=%h dr=%h expected 0 0 0 %h %h",
                  nm, d, i_valid[d], d_valid[d], d_err[d], i_rdata[d], d_rdata[d], lst_i[d], lst_d[d]);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin
         total++;
         if (i_valid[d] !== 1'b0 || d_valid[d] !== 1'b0 || d_err[d] !== 1'b0 ||
             i_rdata[d] !== 32'h0 || d_rdata[d] !== 32'h0) begin
            bad++;
            $display("FAIL reset dut%0d: iv=%0b dv=%0b de=%0b ir=%h dr=%h expected all 0",
                     d, i_valid[d], d_valid[d], d_err[d], i_rdata[d], d_rdata[d]);
         end
      end
   endtask

   task automatic test_basic();
      xfer(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, "basic_wr");
      xfer(0, 1'b1, 1'b0, 32'h10, 32'h0, "basic_rd");
      xfer(0, 1'b0, 1'b0, 32'h10, 32'h0, "basic_irw");
   endtask

   task automatic test_wrap();
      xfer(0, 1'b1, 1'b1, 32'h1004, 32'h12345678, "wrap_wr");
      xfer(0, 1'b1, 1'b0, 32'h4, 32'h0, "wrap_rd");
   endtask

   task automatic test_priority(input int d);
      int n;
      int td;
      int ti;
      xfer(d, 1'b1, 1'b1, 32'h20, $urandom, "prio_pre20");
      xfer(d, 1'b1, 1'b1, 32'h0, $urandom, "prio_pre0");
      @(negedge clk);
      d_addr[d] = 32'h20;
      d_load_n[d] = 1'b0;
      i_addr[d] = 32'h0;
      i_load_n[d] = 1'b0;
      td = -1;
      ti = -1;
      n = 0;
      while ((td < 0 || ti < 0) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         if (d_valid[d] && td < 0) begin
            td = n;
            d_load_n[d] = 1'b1;
            lst_d[d] = mem_m[d][8];
            total++;
            if (d_rdata[d] !== mem_m[d][8]) begin
               bad++;
               $display("FAIL prio d_rdata dut%0d: got=%h expected=%h", d, d_rdata[d], mem_m[d][8]);
            end
         end
         if (i_valid[d] && ti < 0) begin
            ti = n;
            i_load_n[d] = 1'b1;
            lst_i[d] = mem_m[d][0];
            total++;
            if (i_rdata[d] !== mem_m[d][0]) begin
               bad++;
               $display("FAIL prio i_rdata dut%0d: got=%h expected=%h", d, i_rdata[d], mem_m[d][0]);
            end
         end
      end
      i_load_n[d] = 1'b1;
      d_load_n[d] = 1'b1;
      total++;
      if (td != lat_of(d) + 1) begin
         bad++;
         $display("FAIL prio d timing dut%0d: edges=%0d expected=%0d", d, td, lat_of(d) + 1);
      end
      total++;
      if (td < 0 || ti < 0 || ti - td != lat_of(d) + 1) begin
         bad++;
         $display("FAIL prio i gap dut%0d: td=%0d ti=%0d expected gap=%0d", d, td, ti, lat_of(d) + 1);
      end
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic test_hold();
      int pulses;
      int first;
      xfer(2, 1'b1, 1'b1, 32'h30, 32'hCAFE0030, "hold_pre");
      @(negedge clk);
      i_addr[2] = 32'h30;
      i_load_n[2] = 1'b0;
      pulses = 0;
      first = -1;
      for (int n = 1; n <= 13; n++) begin
         @(posedge clk);
         #1;
         if (n == 10) i_load_n[2] = 1'b1;
         if (i_valid[2]) begin
            pulses++;
            if (first < 0) first = n;
         end
      end
      lst_i[2] = 32'hCAFE0030;
      total++;
      if (pulses != 1 || first != 5) begin
         bad++;
         $display("FAIL hold pulses: count=%0d first=%0d expected count=1 first=5", pulses, first);
      end
      total++;
      if (i_rdata[2] !== 32'hCAFE0030) begin
         bad++;
         $display("FAIL hold i_rdata: got=%h expected=%h", i_rdata[2], 32'hCAFE0030);
      end
   endtask

   task automatic test_reset_abort();
      int pulses;
      xfer(1, 1'b1, 1'b1, 32'h8, 32'h0BADF00D, "abort_pre");
      @(negedge clk);
      d_addr[1] = 32'h8;
      d_wdata[1] = 32'hA5A5A5A5;
      d_wen_n[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      d_wen_n[1] = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         lst_i[d] = '0;
         lst_d[d] = '0;
      end
      pulses = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         if (d_valid[1] || d_err[1]) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL abort pulses: count=%0d expected=0", pulses);
      end
      xfer(1, 1'b1, 1'b0, 32'h8, 32'h0, "abort_rd");
   endtask

   task automatic test_misalign();
      xfer(0, 1'b1, 1'b1, 32'h4, 32'h44444444, "mis_pre4");
      xfer(0, 1'b1, 1'b1, 32'h8, 32'h88888888, "mis_pre8");
      xfer(0, 1'b1, 1'b1, 32'h6, 32'h66666666, "mis_wr6");
      xfer(0, 1'b1, 1'b0, 32'h4, 32'h0, "mis_rd4");
      xfer(0, 1'b1, 1'b0, 32'h8, 32'h0, "mis_rd8");
      xfer(0, 1'b0, 1'b0, 32'h5, 32'h0, "mis_ird5");
   endtask

   task automatic test_random();
      logic [31:0] a;
      bit dp;
      bit wr;
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 8; k++)
            xfer(d, 1'b1, 1'b1, 32'(100 + 7 * k) << 2, $urandom, "rnd_init");
         for (int t = 0; t < 25; t++) begin
            dp = 1'($urandom_range(0, 1));
            wr = dp && 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_F000) | ((32'(100 + 7 * $urandom_range(0, 7))) << 2)
                | 32'($urandom_range(0, 3));
            xfer(d, dp, wr, a, $urandom, "rnd");
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         i_load_n[d] = 1'b1;
         d_load_n[d] = 1'b1;
         d_wen_n[d]  = 1'b1;
         i_addr[d]   = '0;
         d_addr[d]   = '0;
         d_wdata[d]  = '0;
         lst_i[d]    = '0;
         lst_d[d]    = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_basic();
      test_wrap();
      test_priority(0);
      test_priority(1);
      test_hold();
      test_reset_abort();
      test_misalign();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
